instr_mem_sync: RTL and testbench
=================================

Name: instr_mem_sync

Overview:
- Parametrised, synchronous-read instruction memory; the next generation of the CPU's fixed 256x32 combinational instruction store.
- Adds a runtime program-load port, a registered fetch port with request/valid handshake, and out-of-range fault reporting.
- Adds a post-reset clear sequencer that fills every word with a NOP.
- Sits between the PC/fetch stage and the decode stage; a testbench or boot loader drives the program port.

Parameters:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 16, fetch/program address width; must satisfy DEPTH <= 2^ADDR_W.
- DEPTH, 256, number of instruction words; need not be a power of two.
- NOP_WORD, 32'h8000_0000, clear/fault word (add r0,r0,r0); width DATA_W.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- init_busy  out  1  high while the clear sequencer runs.
- fetch_req  in  1  fetch request, sampled each rising edge.
- fetch_addr  in  ADDR_W  word address of the fetch.
- fetch_valid  out  1  one-cycle pulse; fetch_data/fetch_fault valid.
- fetch_data  out  DATA_W  fetched instruction.
- fetch_fault  out  1  qualifies fetch_valid; the address was >= DEPTH.
- prog_we  in  1  program-write strobe.
- prog_addr  in  ADDR_W  program-write word address.
- prog_data  in  DATA_W  program-write data.
- prog_ack  out  1  one-cycle pulse; in-range write committed.
- prog_err  out  1  one-cycle pulse; write dropped, address >= DEPTH.

Behaviour:
- State machine: two states, INIT and RUN.
- While rst_n is low:
  - state=INIT, clear counter=0, init_busy=1.
  - fetch_valid, fetch_data, fetch_fault, prog_ack and prog_err are all 0.
- INIT:
  - Each cycle writes NOP_WORD to mem[counter], then counter++.
  - After writing DEPTH-1, moves to RUN on that edge; init_busy falls exactly DEPTH cycles after rst_n rises.
  - fetch_req and prog_we are ignored: no fetch_valid, no prog_ack/prog_err, no write.
- RUN, fetch path:
  - fetch_req=1 at edge N gives fetch_valid=1 during cycle N+1 (latency 1). Back-to-back requests give one result per cycle.
  - In range (fetch_addr < DEPTH): fetch_data=mem[fetch_addr] as stored before edge N, fetch_fault=0.
  - Out of range (fetch_addr >= DEPTH): fetch_data=NOP_WORD, fetch_fault=1. Addresses never wrap modulo DEPTH.
  - fetch_req=0: fetch_valid=0 and fetch_fault=0 next cycle; fetch_data holds its last value.
- RUN, program path:
  - prog_we=1 with prog_addr < DEPTH at edge N: the write commits at edge N; prog_ack=1 in cycle N+1.
  - prog_addr >= DEPTH: memory unchanged; prog_err=1 in cycle N+1.
  - Back-to-back writes are allowed, one per cycle.
- Simultaneous fetch and write to the same address on one edge: read-first. The fetch returns the old word; the new word is visible to fetches from the next edge on.
- Simultaneous fetch and write to different addresses: fully independent.
- Reset mid-operation (INIT or RUN):
  - Asynchronously forces the reset values above.
  - In-flight fetch_valid/prog_ack is lost.
  - The full clear sequence reruns, so all prior contents are lost.
- No combinational path from any input to any output; every output comes straight from a flop.

Test Plan:
- Reset/clear, DEPTH=256: release rst_n. Require init_busy high for exactly 256 cycles. Require fetch_req=1 during init to produce no fetch_valid. After RUN, fetch addr 0, 100, 255: each returns 32'h8000_0000 with fetch_fault=0.
- Program then fetch: write 14 words to addresses 0..13 (e.g. addr0=32'h0E0000FF). Require 14 prog_ack pulses. Then fetch 0..13 back-to-back: fetch_valid high 14 consecutive cycles, each word matches, latency 1.
- Out of range: write addr 256. Require prog_err pulse, no prog_ack, and mem[0] unchanged. Fetch addr 300: require fetch_valid=1, fetch_fault=1, fetch_data=32'h8000_0000.
- Read-first collision: mem[5]=32'h1111_1111. Same edge: write 32'h2222_2222 to addr 5 and fetch addr 5. Require 32'h1111_1111. Next fetch of addr 5 requires 32'h2222_2222.
- Reset mid-run: program addr 3=32'hA5A5_A5A5, pulse rst_n low for 2 cycles during a fetch. Require fetch_valid dropping to 0 immediately and init_busy=1 again. After init, addr 3 returns NOP_WORD.
- Parameter sweep DEPTH=10, ADDR_W=4: require init lasting exactly 10 cycles. Fetch addr 9 requires fetch_fault=0. Fetch addr 10 and 15 each require fetch_fault=1.

Source files
------------

// File: rtl/instr_mem_sync_if.sv
// Fetch and program-load bus of the synchronous instruction memory.
// master = fetch stage / boot loader, slave = memory.
interface instr_mem_sync_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_fault;

    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_ack;
    logic              prog_err;

    modport master (
        output fetch_req, fetch_addr, prog_we, prog_addr, prog_data,
        input  fetch_valid, fetch_data, fetch_fault, prog_ack, prog_err
    );

    modport slave (
        input  fetch_req, fetch_addr, prog_we, prog_addr, prog_data,
        output fetch_valid, fetch_data, fetch_fault, prog_ack, prog_err
    );
endinterface

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory with program-load port, registered
// fetch port, out-of-range fault reporting and a post-reset NOP clear.
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | clear sequencer writes NOP_WORD to one word per cycle;
//       | fetch and program requests are ignored
// RUN   | fetches (latency 1, read-first) and program writes served
module instr_mem_sync #(
    parameter int                 DATA_W   = 32,
    parameter int                 ADDR_W   = 16,
    parameter int                 DEPTH    = 256,
    parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(32'h8000_0000)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               init_busy,
    instr_mem_sync_if.slave    bus
);
    localparam int               CNT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              init_busy_q, init_busy_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              fetch_fault_q, fetch_fault_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic              prog_ack_q, prog_ack_d;
    logic              prog_err_q, prog_err_d;

    logic              mem_we;
    logic [CNT_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic fetch_in_range;
    logic prog_in_range;

    // Compare with one extra bit so DEPTH == 2^ADDR_W still works; no wrapping.
    assign fetch_in_range = ({1'b0, bus.fetch_addr} < DEPTH_X);
    assign prog_in_range  = ({1'b0, bus.prog_addr}  < DEPTH_X);

    // Next-state, memory write port and output computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        init_busy_d   = init_busy_q;
        fetch_valid_d = 1'b0;
        fetch_fault_d = 1'b0;
        fetch_data_d  = fetch_data_q;
        prog_ack_d    = 1'b0;
        prog_err_d    = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = cnt_q;
        mem_wdata     = NOP_WORD;

        case (state_q)
            INIT: begin
                mem_we = 1'b1;
                if (cnt_q == LAST) begin
                    state_d     = RUN;
                    init_busy_d = 1'b0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                // Read sees the array before this edge's write: read-first.
                if (bus.fetch_req) begin
                    fetch_valid_d = 1'b1;
                    if (fetch_in_range) begin
                        fetch_data_d = mem_q[bus.fetch_addr[CNT_W-1:0]];
                    end else begin
                        fetch_data_d  = NOP_WORD;
                        fetch_fault_d = 1'b1;
                    end
                end
                if (bus.prog_we) begin
                    if (prog_in_range) begin
                        mem_we     = 1'b1;
                        mem_waddr  = bus.prog_addr[CNT_W-1:0];
                        mem_wdata  = bus.prog_data;
                        prog_ack_d = 1'b1;
                    end else begin
                        prog_err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Control and output registers; reset restarts the clear sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= INIT;
            cnt_q         <= '0;
            init_busy_q   <= 1'b1;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            fetch_data_q  <= '0;
            prog_ack_q    <= 1'b0;
            prog_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            init_busy_q   <= init_busy_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_fault_q <= fetch_fault_d;
            fetch_data_q  <= fetch_data_d;
            prog_ack_q    <= prog_ack_d;
            prog_err_q    <= prog_err_d;
        end
    end

    // Storage array; no reset, contents are rebuilt by the clear sequencer.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign init_busy       = init_busy_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_fault = fetch_fault_q;
    assign bus.fetch_data  = fetch_data_q;
    assign bus.prog_ack    = prog_ack_q;
    assign bus.prog_err    = prog_err_q;
endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: default 256-word instance plus a 10-word,
// 4-bit-address instance, with a plain array model of the memory.
module tb_instr_mem_sync;
    localparam logic [31:0] NOP = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_s;
    logic init_busy0;
    logic init_busy1;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model   [256];
    logic [31:0] model_s [10];

    always #5 clk = ~clk;

    instr_mem_sync_if #(.DATA_W(32), .ADDR_W(16)) bus0 ();
    instr_mem_sync_if #(.DATA_W(32), .ADDR_W(4))  bus1 ();

    instr_mem_sync #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .NOP_WORD(32'h8000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .init_busy(init_busy0), .bus(bus0)
    );

    instr_mem_sync #(.DATA_W(32), .ADDR_W(4), .DEPTH(10), .NOP_WORD(32'h8000_0000)) dut1 (
        .clk(clk), .rst_n(rst_s), .init_busy(init_busy1), .bus(bus1)
    );

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.fetch_req  = 1'b0;
        bus0.fetch_addr = '0;
        bus0.prog_we    = 1'b0;
        bus0.prog_addr  = '0;
        bus0.prog_data  = '0;
    endtask

    task automatic idle1();
        bus1.fetch_req  = 1'b0;
        bus1.fetch_addr = '0;
        bus1.prog_we    = 1'b0;
        bus1.prog_addr  = '0;
        bus1.prog_data  = '0;
    endtask

    // Counts edges until init_busy0 falls while hammering both request inputs.
    task automatic run_init0(output int cycles, output int spurious);
        cycles   = 0;
        spurious = 0;
        bus0.fetch_req  = 1'b1;
        bus0.fetch_addr = 16'd0;
        bus0.prog_we    = 1'b1;
        bus0.prog_addr  = 16'd0;
        bus0.prog_data  = 32'hDEAD_BEEF;
        while (init_busy0 === 1'b1 && cycles < 1000) begin
            wait_edge();
            cycles++;
            if (bus0.fetch_valid !== 1'b0 || bus0.prog_ack !== 1'b0 || bus0.prog_err !== 1'b0)
                spurious++;
        end
        idle0();
        for (int i = 0; i < 256; i++) model[i] = NOP;
    endtask

    task automatic test_reset();
        int cycles, spurious;
        int addrs [3];
        addrs = '{0, 100, 255};
        idle0();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        n_cmp++; if (init_busy0 !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", init_busy0); end
        n_cmp++; if (bus0.fetch_valid !== 1'b0 || bus0.fetch_fault !== 1'b0 || bus0.fetch_data !== 32'h0) begin
            n_err++; $display("FAIL reset_fetch: got v=%b f=%b d=%h want 0/0/0", bus0.fetch_valid, bus0.fetch_fault, bus0.fetch_data); end
        n_cmp++; if (bus0.prog_ack !== 1'b0 || bus0.prog_err !== 1'b0) begin
            n_err++; $display("FAIL reset_prog: got ack=%b err=%b want 0/0", bus0.prog_ack, bus0.prog_err); end
        wait_edge();
        wait_edge();
        rst_n = 1'b1;
        run_init0(cycles, spurious);
        n_cmp++; if (cycles != 256) begin n_err++; $display("FAIL init_len: got %0d want 256", cycles); end
        n_cmp++; if (spurious != 0) begin n_err++; $display("FAIL init_ignore: got %0d responses want 0", spurious); end
        foreach (addrs[k]) begin
            bus0.fetch_req  = 1'b1;
            bus0.fetch_addr = 16'(addrs[k]);
            wait_edge();
            n_cmp++; if (bus0.fetch_valid !== 1'b1 || bus0.fetch_fault !== 1'b0 || bus0.fetch_data !== NOP) begin
                n_err++; $display("FAIL clear_word[%0d]: got v=%b f=%b d=%h want 1/0/%h",
                                  addrs[k], bus0.fetch_valid, bus0.fetch_fault, bus0.fetch_data, NOP); end
        end
        idle0();
        wait_edge();
    endtask

    task automatic test_prog_fetch();
        int acks = 0, errs = 0;
        for (int i = 0; i < 14; i++) begin
            bus0.prog_we   = 1'b1;
            bus0.prog_addr = 16'(i);
            bus0.prog_data = (i == 0) ? 32'h0E00_00FF : $urandom;
            model[i] = bus0.prog_data;
            wait_edge();
            if (bus0.prog_ack === 1'b1) acks++;
            if (bus0.prog_err !== 1'b0) errs++;
        end
        idle0();
        wait_edge();
        n_cmp++; if (acks != 14 || errs != 0) begin n_err++; $display("FAIL prog_acks: got ack=%0d err=%0d want 14/0", acks, errs); end
        n_cmp++; if (bus0.prog_ack !== 1'b0) begin n_err++; $display("FAIL ack_pulse: got %b want 0", bus0.prog_ack); end
        for (int i = 0; i < 14; i++) begin
            bus0.fetch_req  = 1'b1;
            bus0.fetch_addr = 16'(i);
            wait_edge();
            n_cmp++; if (bus0.fetch_valid !== 1'b1 || bus0.fetch_fault !== 1'b0 || bus0.fetch_data !== model[i]) begin
                n_err++; $display("FAIL b2b_fetch[%0d]: got v=%b f=%b d=%h want 1/0/%h",
                                  i, bus0.fetch_valid, bus0.fetch_fault, bus0.fetch_data, model[i]); end
        end
        idle0();
        wait_edge();
        n_cmp++; if (bus0.fetch_valid !== 1'b0 || bus0.fetch_data !== model[13]) begin
            n_err++; $display("FAIL fetch_hold: got v=%b d=%h want 0/%h", bus0.fetch_valid, bus0.fetch_data, model[13]); end
    endtask

    task automatic test_out_of_range();
        bus0.prog_we   = 1'b1;
        bus0.prog_addr = 16'd256;
        bus0.prog_data = 32'hBAD0_BAD0;
        wait_edge();
        idle0();
        n_cmp++; if (bus0.prog_err !== 1'b1 || bus0.prog_ack !== 1'b0) begin
            n_err++; $display("FAIL oor_write: got ack=%b err=%b want 0/1", bus0.prog_ack, bus0.prog_err); end
        bus0.fetch_req  = 1'b1;
        bus0.fetch_addr = 16'd0;
        wait_edge();
        n_cmp++; if (bus0.fetch_data !== model[0]) begin n_err++; $display("FAIL oor_mem0: got %h want %h", bus0.fetch_data, model[0]); end
        bus0.fetch_addr = 16'd300;
        wait_edge();
        n_cmp++; if (bus0.fetch_valid !== 1'b1 || bus0.fetch_fault !== 1'b1 || bus0.fetch_data !== NOP) begin
            n_err++; $display("FAIL oor_fetch300: got v=%b f=%b d=%h want 1/1/%h", bus0.fetch_valid, bus0.fetch_fault, bus0.fetch_data, NOP); end
        bus0.fetch_addr = 16'd256;
        wait_edge();
        n_cmp++; if (bus0.fetch_fault !== 1'b1 || bus0.fetch_data !== NOP) begin
            n_err++; $display("FAIL oor_fetch256: got f=%b d=%h want 1/%h", bus0.fetch_fault, bus0.fetch_data, NOP); end
        idle0();
        wait_edge();
        n_cmp++; if (bus0.fetch_valid !== 1'b0 || bus0.fetch_fault !== 1'b0) begin
            n_err++; $display("FAIL oor_clear: got v=%b f=%b want 0/0", bus0.fetch_valid, bus0.fetch_fault); end
    endtask

    task automatic test_collision();
        bus0.prog_we   = 1'b1;
        bus0.prog_addr = 16'd5;
        bus0.prog_data = 32'h1111_1111;
        model[5] = 32'h1111_1111;
        wait_edge();
        bus0.prog_data  = 32'h2222_2222;
        bus0.fetch_req  = 1'b1;
        bus0.fetch_addr = 16'd5;
        wait_edge();
        bus0.prog_we = 1'b0;
        n_cmp++; if (bus0.fetch_data !== 32'h1111_1111 || bus0.prog_ack !== 1'b1) begin
            n_err++; $display("FAIL read_first: got d=%h ack=%b want 11111111/1", bus0.fetch_data, bus0.prog_ack); end
        model[5] = 32'h2222_2222;
        wait_edge();
        n_cmp++; if (bus0.fetch_data !== 32'h2222_2222) begin
            n_err++; $display("FAIL after_write: got %h want 22222222", bus0.fetch_data); end
        idle0();
        wait_edge();
    endtask

    task automatic test_random();
        logic        req, we;
        int          fa, pa;
        logic [31:0] pd;
        logic        ev, ef, ea, ee;
        logic [31:0] ed;
        ed = 32'h0;
        for (int i = 0; i < 300; i++) begin
            req = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            fa  = $urandom_range(0, 299);
            we  = 1'($urandom_range(0, 1));
            pa  = ($urandom_range(0, 7) == 0) ? fa : $urandom_range(0, 299);
            pd  = $urandom;
            bus0.fetch_req  = req;
            bus0.fetch_addr = 16'(fa);
            bus0.prog_we    = we;
            bus0.prog_addr  = 16'(pa);
            bus0.prog_data  = pd;
            ev = req;
            ef = req && (fa >= 256);
            if (req) ed = (fa < 256) ? model[fa] : NOP;
            ea = we && (pa < 256);
            ee = we && (pa >= 256);
            if (ea) model[pa] = pd;
            wait_edge();
            n_cmp++; if (bus0.fetch_valid !== ev || bus0.fetch_fault !== ef || bus0.fetch_data !== ed) begin
                n_err++; $display("FAIL rnd_fetch[%0d]: got v=%b f=%b d=%h want %b/%b/%h",
                                  i, bus0.fetch_valid, bus0.fetch_fault, bus0.fetch_data, ev, ef, ed); end
            n_cmp++; if (bus0.prog_ack !== ea || bus0.prog_err !== ee) begin
                n_err++; $display("FAIL rnd_prog[%0d]: got ack=%b err=%b want %b/%b", i, bus0.prog_ack, bus0.prog_err, ea, ee); end
        end
        idle0();
        wait_edge();
    endtask

    task automatic test_reset_mid();
        int cycles, spurious;
        bus0.prog_we   = 1'b1;
        bus0.prog_addr = 16'd3;
        bus0.prog_data = 32'hA5A5_A5A5;
        wait_edge();
        idle0();
        bus0.fetch_req  = 1'b1;
        bus0.fetch_addr = 16'd3;
        wait_edge();
        n_cmp++; if (bus0.fetch_valid !== 1'b1 || bus0.fetch_data !== 32'hA5A5_A5A5) begin
            n_err++; $display("FAIL pre_reset_fetch: got v=%b d=%h want 1/a5a5a5a5", bus0.fetch_valid, bus0.fetch_data); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus0.fetch_valid !== 1'b0 || init_busy0 !== 1'b1) begin
            n_err++; $display("FAIL mid_reset: got v=%b busy=%b want 0/1", bus0.fetch_valid, init_busy0); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_init0(cycles, spurious);
        n_cmp++; if (cycles != 256 || spurious != 0) begin
            n_err++; $display("FAIL reinit: got cycles=%0d spurious=%0d want 256/0", cycles, spurious); end
        bus0.fetch_req  = 1'b1;
        bus0.fetch_addr = 16'd3;
        wait_edge();
        n_cmp++; if (bus0.fetch_data !== NOP || bus0.fetch_valid !== 1'b1) begin
            n_err++; $display("FAIL lost_contents: got v=%b d=%h want 1/%h", bus0.fetch_valid, bus0.fetch_data, NOP); end
        idle0();
        wait_edge();
    endtask

    task automatic test_small_depth();
        int cycles = 0;
        int addrs [3];
        logic [31:0] w;
        addrs = '{9, 10, 15};
        idle1();
        rst_s = 1'b1;
        while (init_busy1 === 1'b1 && cycles < 100) begin
            wait_edge();
            cycles++;
        end
        n_cmp++; if (cycles != 10) begin n_err++; $display("FAIL small_init_len: got %0d want 10", cycles); end
        for (int i = 0; i < 10; i++) model_s[i] = NOP;
        foreach (addrs[k]) begin
            bus1.fetch_req  = 1'b1;
            bus1.fetch_addr = 4'(addrs[k]);
            wait_edge();
            n_cmp++; if (bus1.fetch_valid !== 1'b1 || bus1.fetch_fault !== (addrs[k] >= 10) || bus1.fetch_data !== NOP) begin
                n_err++; $display("FAIL small_fetch[%0d]: got v=%b f=%b d=%h want 1/%b/%h",
                                  addrs[k], bus1.fetch_valid, bus1.fetch_fault, bus1.fetch_data, (addrs[k] >= 10), NOP); end
        end
        idle1();
        w = $urandom;
        bus1.prog_we   = 1'b1;
        bus1.prog_addr = 4'd9;
        bus1.prog_data = w;
        model_s[9] = w;
        wait_edge();
        bus1.prog_addr = 4'd10;
        wait_edge();
        n_cmp++; if (bus1.prog_err !== 1'b1 || bus1.prog_ack !== 1'b0) begin
            n_err++; $display("FAIL small_oor_write: got ack=%b err=%b want 0/1", bus1.prog_ack, bus1.prog_err); end
        idle1();
        bus1.fetch_req  = 1'b1;
        bus1.fetch_addr = 4'd9;
        wait_edge();
        n_cmp++; if (bus1.fetch_data !== model_s[9] || bus1.fetch_fault !== 1'b0) begin
            n_err++; $display("FAIL small_readback: got f=%b d=%h want 0/%h", bus1.fetch_fault, bus1.fetch_data, model_s[9]); end
        idle1();
        wait_edge();
    endtask

    initial begin
        rst_n = 1'b1;
        rst_s = 1'b1;
        idle0();
        idle1();
        #1;
        rst_s = 1'b0;
        test_reset();
        test_prog_fetch();
        test_out_of_range();
        test_collision();
        test_random();
        test_reset_mid();
        test_small_depth();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
